// File: rtl/vga_pkg.sv
// Shared 640x480 timing constants, total derivation and lock-state encoding.
// Used by the VGA timing source and by vga_sync_rx so both agree on values.
package vga_pkg;

  localparam int H_ACTIVE_D = 640;
  localparam int H_FP_D     = 16;
  localparam int H_SW_D     = 96;
  localparam int H_BP_D     = 48;

  localparam int V_ACTIVE_D = 480;
  localparam int V_FP_D     = 10;
  localparam int V_SW_D     = 2;
  localparam int V_BP_D     = 33;

  localparam int XW = 10;
  localparam int YW = 10;
  localparam int PW = 19;

  typedef enum logic [1:0] {
    SEARCH  = 2'd0,
    ACQUIRE = 2'd1,
    LOCKED  = 2'd2
  } lock_st_e;

  function automatic int vga_total(
    input int act,
    input int fp,
    input int sw,
    input int bp
  );
    return act + fp + sw + bp;
  endfunction

  localparam int H_TOTAL_D =
    vga_total(H_ACTIVE_D, H_FP_D, H_SW_D, H_BP_D);
  localparam int V_TOTAL_D =
    vga_total(V_ACTIVE_D, V_FP_D, V_SW_D, V_BP_D);

endpackage

// File: rtl/vga_sync_rx_if.sv
// Sync/pixel inputs and recovered timing outputs of vga_sync_rx.
// master = timing source / consumer side, slave = the receiver.
interface vga_sync_rx_if;

  logic                    h_sync;
  logic                    v_sync;
  logic                    pixel;
  logic [vga_pkg::XW-1:0]  x;
  logic [vga_pkg::YW-1:0]  y;
  logic                    de;
  logic [vga_pkg::PW-1:0]  p_count;
  logic                    locked;
  logic                    h_err;
  logic                    v_err;
  logic                    pix_err;
  logic                    frame_start;

  modport master (
    output h_sync, v_sync, pixel,
    input  x, y, de, p_count, locked,
    input  h_err, v_err, pix_err, frame_start
  );

  modport slave (
    input  h_sync, v_sync, pixel,
    output x, y, de, p_count, locked,
    output h_err, v_err, pix_err, frame_start
  );

endinterface

// File: rtl/vga_sync_edge.sv
// Sync input register, polarity normalisation and leading-edge detect.
// o_lead is high for the sample that is the first active one after an inactive one.
module vga_sync_edge #(
  parameter bit SYNC_NEG = 1'b1
) (
  input  logic i_clk,
  input  logic i_rst_n,
  input  logic i_sync,
  output logic o_lead
);

  logic r_sync;
  logic w_act;
  logic w_act_prev;

  always_ff @(posedge i_clk or negedge i_rst_n) begin
    if (!i_rst_n) begin
      r_sync <= SYNC_NEG;
    end else begin
      r_sync <= i_sync;
    end
  end

  assign w_act      = i_sync ^ SYNC_NEG;
  assign w_act_prev = r_sync ^ SYNC_NEG;
  assign o_lead     = w_act & ~w_act_prev;

endmodule

// File: rtl/vga_sync_rx.sv
// Recovers X/Y/DE/pixel index from VGA syncs and tracks lock.
// Define VGA_SYNC_RX_PCOUNT_EN to compile in the linear pixel index.
module vga_sync_rx
  import vga_pkg::*;
#(
  parameter int H_ACTIVE = H_ACTIVE_D,
  parameter int H_FP     = H_FP_D,
  parameter int H_SW     = H_SW_D,
  parameter int H_BP     = H_BP_D,
  parameter int V_ACTIVE = V_ACTIVE_D,
  parameter int V_FP     = V_FP_D,
  parameter int V_SW     = V_SW_D,
  parameter int V_BP     = V_BP_D,
  parameter bit SYNC_NEG = 1'b1
) (
  input logic          i_clk,
  input logic          i_rst_n,
  vga_sync_rx_if.slave vga
);

  localparam int H_TOTAL = vga_total(H_ACTIVE, H_FP, H_SW, H_BP);
  localparam int V_TOTAL = vga_total(V_ACTIVE, V_FP, V_SW, V_BP);
  localparam int H_LOAD  = H_ACTIVE + H_FP;
  localparam int V_LOAD  = V_ACTIVE + V_FP;
  localparam int TO_LIM  = 2 * H_TOTAL;
  localparam int TW      = $clog2(TO_LIM + 1);

  lock_st_e        r_state;
  lock_st_e        w_state_n;
  logic            r_vcnt;
  logic            w_vcnt_n;
  logic [TW-1:0]   r_hto;
  logic [TW-1:0]   w_hto_n;
  logic            w_tmo;

  logic [XW-1:0]   r_x;
  logic [YW-1:0]   r_y;
  logic [XW-1:0]   w_x_free;
  logic [YW-1:0]   w_y_free;
  logic [XW-1:0]   w_x_n;
  logic [YW-1:0]   w_y_n;
  logic            w_x_wrap;

  logic            w_hl;
  logic            w_vl;
  logic            w_h_err;
  logic            w_v_err;

  logic            w_lock_n;
  logic            w_de_n;
  logic            w_pix_err_n;
  logic            w_fs_n;
  logic [PW-1:0]   w_pc_n;

  logic            r_lock;
  logic            r_de;
  logic [PW-1:0]   r_pc;
  logic            r_h_err;
  logic            r_v_err;
  logic            r_pix_err;
  logic            r_fs;

  vga_sync_edge #(.SYNC_NEG(SYNC_NEG)) u_hs (
    .i_clk   (i_clk),
    .i_rst_n (i_rst_n),
    .i_sync  (vga.h_sync),
    .o_lead  (w_hl)
  );

  vga_sync_edge #(.SYNC_NEG(SYNC_NEG)) u_vs (
    .i_clk   (i_clk),
    .i_rst_n (i_rst_n),
    .i_sync  (vga.v_sync),
    .o_lead  (w_vl)
  );

  // Free-running position; sync edges override it.
  assign w_x_wrap = (r_x == XW'(H_TOTAL - 1));
  assign w_x_free = w_x_wrap ? '0 : r_x + 1'b1;
  assign w_y_free = !w_x_wrap ? r_y :
                    (r_y == YW'(V_TOTAL - 1)) ? '0 : r_y + 1'b1;
  assign w_x_n    = w_hl ? XW'(H_LOAD) : w_x_free;
  assign w_y_n    = w_vl ? YW'(V_LOAD) : w_y_free;

  assign w_h_err  = w_hl && (w_x_free != XW'(H_LOAD)) &&
                    (r_state != SEARCH);
  assign w_v_err  = w_vl && (w_y_free != YW'(V_LOAD)) &&
                    (r_state == LOCKED);

  assign w_hto_n  = w_hl ? '0 :
                    (r_hto == TW'(TO_LIM)) ? r_hto : r_hto + 1'b1;
  assign w_tmo    = (w_hto_n == TW'(TO_LIM));

  always_comb begin
    w_state_n = r_state;
    w_vcnt_n  = r_vcnt;
    unique case (r_state)
      SEARCH: begin
        if (w_hl) begin
          w_state_n = ACQUIRE;
          w_vcnt_n  = 1'b0;
        end
      end
      ACQUIRE: begin
        if (w_h_err) begin
          w_vcnt_n = w_vl;
        end else if (w_vl) begin
          if (r_vcnt) w_state_n = LOCKED;
          w_vcnt_n = 1'b1;
        end
      end
      LOCKED: begin
        if (w_h_err || w_v_err) begin
          w_state_n = ACQUIRE;
          w_vcnt_n  = 1'b0;
        end
      end
      default: begin
        w_state_n = SEARCH;
        w_vcnt_n  = 1'b0;
      end
    endcase
    if (w_tmo) begin
      w_state_n = SEARCH;
      w_vcnt_n  = 1'b0;
    end
  end

  // Flags describe the sample being registered this edge.
  assign w_lock_n    = (w_state_n == LOCKED);
  assign w_de_n      = w_lock_n &&
                       (w_x_n < XW'(H_ACTIVE)) &&
                       (w_y_n < YW'(V_ACTIVE));
  assign w_pix_err_n = w_lock_n && !w_de_n && vga.pixel;
  assign w_fs_n      = w_lock_n && (w_x_n == '0) && (w_y_n == '0);

`ifdef VGA_SYNC_RX_PCOUNT_EN
  localparam logic [PW-1:0] HA_V = PW'(H_ACTIVE);

  function automatic logic [PW-1:0] mul_ha(input logic [YW-1:0] yv);
    logic [PW-1:0] acc;
    acc = '0;
    for (int b = 0; b < PW; b++) begin
      if (HA_V[b]) acc = acc + (PW'(yv) << b);
    end
    return acc;
  endfunction

  assign w_pc_n = w_de_n ? mul_ha(w_y_n) + PW'(w_x_n) : '0;
`else
  assign w_pc_n = '0;
`endif

  always_ff @(posedge i_clk or negedge i_rst_n) begin
    if (!i_rst_n) begin
      r_state   <= SEARCH;
      r_vcnt    <= 1'b0;
      r_hto     <= '0;
      r_x       <= '0;
      r_y       <= '0;
      r_lock    <= 1'b0;
      r_de      <= 1'b0;
      r_pc      <= '0;
      r_h_err   <= 1'b0;
      r_v_err   <= 1'b0;
      r_pix_err <= 1'b0;
      r_fs      <= 1'b0;
    end else begin
      r_state   <= w_state_n;
      r_vcnt    <= w_vcnt_n;
      r_hto     <= w_hto_n;
      r_x       <= w_x_n;
      r_y       <= w_y_n;
      r_lock    <= w_lock_n;
      r_de      <= w_de_n;
      r_pc      <= w_pc_n;
      r_h_err   <= w_h_err;
      r_v_err   <= w_v_err;
      r_pix_err <= w_pix_err_n;
      r_fs      <= w_fs_n;
    end
  end

  assign vga.x           = r_x;
  assign vga.y           = r_y;
  assign vga.de          = r_de;
  assign vga.p_count     = r_pc;
  assign vga.locked      = r_lock;
  assign vga.h_err       = r_h_err;
  assign vga.v_err       = r_v_err;
  assign vga.pix_err     = r_pix_err;
  assign vga.frame_start = r_fs;

endmodule

// File: doc/vga_sync_rx.md
VGA_SYNC_RX -- requirements
Module: vga_sync_rx

Interface
REQ-001 Parameter H_ACTIVE, default 640, visible pixels per line.
REQ-002 Parameter H_FP / H_SW / H_BP, defaults 16 / 96 / 48, horizontal front porch, sync width and back porch in clocks; H_TOTAL = sum = 800.
REQ-003 Parameter V_ACTIVE / V_FP / V_SW / V_BP, defaults 480 / 10 / 2 / 33, in lines; V_TOTAL = 525.
REQ-004 Parameter SYNC_NEG, default 1, 1 = H_SYNC/V_SYNC active-low, 0 = active-high.
REQ-005 CLK  input  1  pixel clock; all logic on its rising edge.
REQ-006 RST_N  input  1  reset, asynchronous assert, active-low.
REQ-007 H_SYNC, V_SYNC  input  1 each  sync from a VGA640x480-style timing source.
REQ-008 PIXEL  input  1  pixel data from the same source.
REQ-009 X, Y  output  10 each  recovered column 0..H_TOTAL-1 and line 0..V_TOTAL-1.
REQ-010 DE  output  1  recovered active-video flag.
REQ-011 P_COUNT  output  19  recovered linear pixel index.
REQ-012 LOCKED  output  1  timing locked.
REQ-013 H_ERR, V_ERR, PIX_ERR  output  1 each  one-cycle error strobes.
REQ-014 FRAME_START  output  1  one-cycle strobe at X=0, Y=0.

Function
REQ-015 Inputs are registered once; all outputs describe the input sample taken one CLK earlier (latency 1).
REQ-016 Sync leading edge = first registered sample at active level after an inactive sample; polarity per SYNC_NEG.
REQ-017 X free-runs +1 per clock and wraps H_TOTAL-1 -> 0; Y increments on each X wrap and wraps V_TOTAL-1 -> 0.
REQ-018 On H_SYNC leading edge, X loads H_ACTIVE+H_FP (656).
REQ-019 On V_SYNC leading edge, Y loads V_ACTIVE+V_FP (490); X is unaffected.
REQ-020 H_ERR pulses when an H_SYNC leading edge arrives while free-running X would not have been 656, in ACQUIRE or LOCKED.
REQ-021 V_ERR pulses when a V_SYNC leading edge arrives while free-running Y would not have been 490, in LOCKED only.
REQ-022 Lock FSM states: SEARCH, ACQUIRE, LOCKED.
REQ-023 SEARCH -> ACQUIRE on first H_SYNC leading edge.
REQ-024 ACQUIRE -> LOCKED on the second consecutive V_SYNC leading edge with no H_ERR since the first one.
REQ-025 An H_ERR in ACQUIRE restarts the V_SYNC edge count.
REQ-026 LOCKED -> ACQUIRE on H_ERR or V_ERR.
REQ-027 Any state -> SEARCH when no H_SYNC leading edge occurs for 2*H_TOTAL consecutive clocks.
REQ-028 LOCKED = 1 only in LOCKED state.
REQ-029 DE = LOCKED and X < H_ACTIVE and Y < V_ACTIVE.
REQ-030 P_COUNT = Y*H_ACTIVE + X when DE, else 0, using shift-add and no multiplier.
REQ-031 PIX_ERR pulses when LOCKED and DE = 0 and PIXEL = 1.
REQ-032 FRAME_START pulses when LOCKED and X = 0 and Y = 0.
REQ-033 Simultaneous H and V leading edges: both loads apply in the same cycle.

Reset
REQ-034 RST_N low asynchronously forces SEARCH, X = 0, Y = 0, input registers to the inactive sync level, and all outputs to 0.
REQ-035 Release is synchronous to CLK.
REQ-036 Reset mid-frame discards lock; reacquisition follows REQ-023/024.

Configuration
REQ-037 Macro VGA_SYNC_RX_PCOUNT_EN defined: P_COUNT logic per REQ-030 is compiled in.
REQ-038 Macro VGA_SYNC_RX_PCOUNT_EN undefined: P_COUNT is tied to 0 and its arithmetic is absent.

Structure
REQ-039 Shared package vga_pkg holds the 640x480 timing constants, the H_TOTAL/V_TOTAL derivation and the lock-state encoding, so the generator and this block use identical values.
REQ-040 Sub-module vga_sync_edge contains the input register, polarity normalisation and leading-edge detect; it is instanced once per sync.

Verification
REQ-041 Drive VGA640x480 source for 3 frames after reset -> LOCKED = 1 at the start of frame 3, no H_ERR/V_ERR/PIX_ERR, DE high for 307200 clocks per frame.
REQ-042 Locked, sample pixel (639,479) -> X = 639, Y = 479, P_COUNT = 307199; next clock DE = 0.
REQ-043 Locked, shift one H_SYNC edge by +1 clock -> H_ERR strobe once, LOCKED = 0, relocked 2 frames later.
REQ-044 Locked, hold H_SYNC inactive for 1600 clocks -> state SEARCH, LOCKED = 0, DE = 0.
REQ-045 Locked, PIXEL = 1 at X = 700 -> single PIX_ERR pulse.
REQ-046 RST_N low mid-frame for 1 clock -> X = Y = 0 and LOCKED = 0 immediately, without waiting for CLK; build without VGA_SYNC_RX_PCOUNT_EN -> P_COUNT = 0 throughout.
